// File: rtl/decode_64b_66b_mc_if.sv
// Block-side and XGMII-side bundle of the multi-channel 64b/66b decoder.
// Channel k occupies index [k] of every packed per-channel field.
interface decode_64b_66b_mc_if #(
    parameter int CH_NUM    = 1,
    parameter int ERR_CNT_W = 16
);
    logic [CH_NUM-1:0][63:0]          decode_data_i;
    logic [CH_NUM-1:0][1:0]           decode_head_i;
    logic [CH_NUM-1:0]                decode_data_vld_i;
    logic [CH_NUM-1:0]                block_lock_i;
    logic                             err_cnt_clr_i;
    logic [CH_NUM-1:0][63:0]          xgmii_rxd_o;
    logic [CH_NUM-1:0][7:0]           xgmii_rxc_o;
    logic [CH_NUM-1:0]                xgmii_rxd_vld_o;
    logic [CH_NUM-1:0]                decode_error_o;
    logic [CH_NUM-1:0][ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output decode_data_i, decode_head_i, decode_data_vld_i, block_lock_i, err_cnt_clr_i,
        input  xgmii_rxd_o, xgmii_rxc_o, xgmii_rxd_vld_o, decode_error_o, err_cnt_o
    );

    modport slave (
        input  decode_data_i, decode_head_i, decode_data_vld_i, block_lock_i, err_cnt_clr_i,
        output xgmii_rxd_o, xgmii_rxc_o, xgmii_rxd_vld_o, decode_error_o, err_cnt_o
    );
endinterface

// File: rtl/decode_64b_66b_mc.sv
// Multi-channel Clause-49 64b/66b RX decoder: block decode, one-block lookahead, IEEE RX FSM.
// Define DECODE_ERR_CNT_EN to build the per-channel saturating error counters.

module decode_64b_66b_ch #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [63:0]          decode_data_i,
    input  logic [1:0]           decode_head_i,
    input  logic                 decode_data_vld_i,
    input  logic                 block_lock_i,
    input  logic                 err_cnt_clr_i,
    output logic [63:0]          xgmii_rxd_o,
    output logic [7:0]           xgmii_rxc_o,
    output logic                 xgmii_rxd_vld_o,
    output logic                 decode_error_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    typedef enum logic [2:0] {BT_C, BT_S, BT_T, BT_D, BT_E} blk_e;
    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_st_e;

    localparam logic [63:0] IDLE_D = {8{8'h07}};
    localparam logic [63:0] ERR_D  = {8{8'hFE}};
    localparam logic [63:0] LF_D   = 64'h0100009C_0100009C;

    // 7-bit control code to XGMII byte; bit 8 flags an illegal code
    function automatic logic [8:0] ctl_map(input logic [6:0] code);
        case (code)
            7'h00:   ctl_map = {1'b0, 8'h07};
            7'h1E:   ctl_map = {1'b0, 8'hFE};
            default: ctl_map = {1'b1, 8'hFE};
        endcase
    endfunction

    logic [63:0] dec_rxd;
    logic [7:0]  dec_rxc;
    blk_e        dec_typ;
    logic [63:0] t_src;
    logic [8:0]  cm;
    logic        bad;
    logic        is_t;
    int          t_pos;

    always_comb begin
        dec_rxd = decode_data_i;
        dec_rxc = 8'h00;
        dec_typ = BT_E;
        bad     = 1'b0;
        is_t    = 1'b0;
        t_pos   = 0;
        cm      = '0;
        t_src   = {8'h07, decode_data_i[63:8]};
        if (decode_head_i == 2'b10) begin
            dec_typ = BT_D;
        end else if (decode_head_i == 2'b01) begin
            case (decode_data_i[7:0])
                8'h1E: begin
                    dec_typ = BT_C;
                    dec_rxc = 8'hFF;
                    for (int i = 0; i < 8; i++) begin
                        cm = ctl_map(decode_data_i[8+7*i +: 7]);
                        bad |= cm[8];
                        dec_rxd[8*i +: 8] = cm[7:0];
                    end
                end
                8'h2D, 8'h33: begin
                    dec_typ = (decode_data_i[7:0] == 8'h2D) ? BT_C : BT_S;
                    dec_rxc = 8'h1F;
                    for (int i = 0; i < 4; i++) begin
                        cm = ctl_map(decode_data_i[8+7*i +: 7]);
                        bad |= cm[8];
                        dec_rxd[8*i +: 8] = cm[7:0];
                    end
                    dec_rxd[39:32] = (decode_data_i[7:0] == 8'h2D) ? 8'h9C : 8'hFB;
                end
                8'h4B: begin
                    dec_typ = BT_C;
                    dec_rxc = 8'hF1;
                    dec_rxd[7:0] = 8'h9C;
                    // upper control codes share the 7-bit grid of the all-control block
                    for (int i = 4; i < 8; i++) begin
                        cm = ctl_map(decode_data_i[8+7*i +: 7]);
                        bad |= cm[8];
                        dec_rxd[8*i +: 8] = cm[7:0];
                    end
                end
                8'h55, 8'h66: begin
                    dec_typ = (decode_data_i[7:0] == 8'h55) ? BT_C : BT_S;
                    dec_rxc = 8'h11;
                    dec_rxd[7:0]   = 8'h9C;
                    dec_rxd[39:32] = (decode_data_i[7:0] == 8'h55) ? 8'h9C : 8'hFB;
                end
                8'h78: begin
                    dec_typ = BT_S;
                    dec_rxc = 8'h01;
                    dec_rxd[7:0] = 8'hFB;
                end
                8'h87: begin is_t = 1'b1; t_pos = 0; end
                8'h99: begin is_t = 1'b1; t_pos = 1; end
                8'hAA: begin is_t = 1'b1; t_pos = 2; end
                8'hB4: begin is_t = 1'b1; t_pos = 3; end
                8'hCC: begin is_t = 1'b1; t_pos = 4; end
                8'hD2: begin is_t = 1'b1; t_pos = 5; end
                8'hE1: begin is_t = 1'b1; t_pos = 6; end
                8'hFF: begin is_t = 1'b1; t_pos = 7; end
                default: dec_typ = BT_E;
            endcase
            if (is_t) begin
                dec_typ = BT_T;
                dec_rxc = 8'hFF << t_pos;
                for (int i = 0; i < 8; i++)
                    dec_rxd[8*i +: 8] = (i < t_pos) ? t_src[8*i +: 8] :
                                        (i == t_pos) ? 8'hFD : 8'h07;
            end
            if (bad) dec_typ = BT_E;
        end
    end

    rx_st_e      st_q, st_d, st_nxt;
    logic        la_vld_q, la_vld_d;
    blk_e        la_typ_q, la_typ_d;
    logic [63:0] la_rxd_q, la_rxd_d, rxd_q, rxd_d;
    logic [7:0]  la_rxc_q, la_rxc_d, rxc_q, rxc_d;
    logic        vld_q, vld_d, err_q, err_d;
    logic        nxt_cs;

    // FSM judges the held block; the incoming block serves as its lookahead
    always_comb begin
        st_nxt   = RX_E;
        nxt_cs   = (dec_typ == BT_C) || (dec_typ == BT_S);
        st_d     = st_q;
        la_vld_d = la_vld_q;
        la_typ_d = la_typ_q;
        la_rxd_d = la_rxd_q;
        la_rxc_d = la_rxc_q;
        rxd_d    = rxd_q;
        rxc_d    = rxc_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        case (st_q)
            RX_D:    st_nxt = (la_typ_q == BT_D) ? RX_D :
                              (la_typ_q == BT_T && nxt_cs) ? RX_T : RX_E;
            RX_E:    st_nxt = (la_typ_q == BT_C) ? RX_C :
                              (la_typ_q == BT_D) ? RX_D :
                              (la_typ_q == BT_T && nxt_cs) ? RX_T : RX_E;
            default: st_nxt = (la_typ_q == BT_C) ? RX_C :
                              (la_typ_q == BT_S) ? RX_D : RX_E;
        endcase
        if (!block_lock_i) begin
            st_d     = RX_INIT;
            la_vld_d = 1'b0;
            vld_d    = 1'b1;
            rxd_d    = LF_D;
            rxc_d    = 8'h11;
        end else if (decode_data_vld_i) begin
            la_vld_d = 1'b1;
            la_typ_d = dec_typ;
            la_rxd_d = dec_rxd;
            la_rxc_d = dec_rxc;
            if (la_vld_q) begin
                vld_d = 1'b1;
                st_d  = st_nxt;
                if (st_nxt == RX_E) begin
                    rxd_d = ERR_D;
                    rxc_d = 8'hFF;
                    err_d = 1'b1;
                end else begin
                    rxd_d = la_rxd_q;
                    rxc_d = la_rxc_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q     <= RX_INIT;
            la_vld_q <= 1'b0;
            la_typ_q <= BT_E;
            la_rxd_q <= IDLE_D;
            la_rxc_q <= 8'hFF;
            rxd_q    <= IDLE_D;
            rxc_q    <= 8'hFF;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            la_vld_q <= la_vld_d;
            la_typ_q <= la_typ_d;
            la_rxd_q <= la_rxd_d;
            la_rxc_q <= la_rxc_d;
            rxd_q    <= rxd_d;
            rxc_q    <= rxc_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign xgmii_rxd_o     = rxd_q;
    assign xgmii_rxc_o     = rxc_q;
    assign xgmii_rxd_vld_o = vld_q;
    assign decode_error_o  = err_q;

`ifdef DECODE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_q;

    // counts alongside the error beat so the value already includes it
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || err_cnt_clr_i) cnt_q <= '0;
        else if (err_d && !(&cnt_q))   cnt_q <= cnt_q + ERR_CNT_W'(1);
    end

    assign err_cnt_o = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = err_cnt_clr_i;
    assign err_cnt_o  = '0;
`endif
endmodule

module decode_64b_66b_mc #(
    parameter int CH_NUM    = 1,
    parameter int ERR_CNT_W = 16
) (
    input logic               clk_i,
    input logic               rst_n_i,
    decode_64b_66b_mc_if.slave bus
);
    logic [CH_NUM-1:0][63:0]          rxd_w;
    logic [CH_NUM-1:0][7:0]           rxc_w;
    logic [CH_NUM-1:0]                vld_w;
    logic [CH_NUM-1:0]                err_w;
    logic [CH_NUM-1:0][ERR_CNT_W-1:0] cnt_w;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        decode_64b_66b_ch #(.ERR_CNT_W(ERR_CNT_W)) u_ch (
            .clk_i            (clk_i),
            .rst_n_i          (rst_n_i),
            .decode_data_i    (bus.decode_data_i[k]),
            .decode_head_i    (bus.decode_head_i[k]),
            .decode_data_vld_i(bus.decode_data_vld_i[k]),
            .block_lock_i     (bus.block_lock_i[k]),
            .err_cnt_clr_i    (bus.err_cnt_clr_i),
            .xgmii_rxd_o      (rxd_w[k]),
            .xgmii_rxc_o      (rxc_w[k]),
            .xgmii_rxd_vld_o  (vld_w[k]),
            .decode_error_o   (err_w[k]),
            .err_cnt_o        (cnt_w[k])
        );
    end

    assign bus.xgmii_rxd_o     = rxd_w;
    assign bus.xgmii_rxc_o     = rxc_w;
    assign bus.xgmii_rxd_vld_o = vld_w;
    assign bus.decode_error_o  = err_w;
    assign bus.err_cnt_o       = cnt_w;
endmodule
